prog_loader: RTL and testbench

Write-side counterpart of the instruction memory. Accepts a byte-serial program image over a valid/ready stream, assembles big-endian 16-bit instruction words, and writes them into instruction RAM at consecutive word addresses starting at 0. It holds the processor core stalled via `cpu_hold` while a load is in progress, and it validates the image length and an XOR checksum.

---
 rtl/prog_loader.sv | 114 +++++++++++
 tb/tb_prog_loader.sv | 323 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Byte-serial program loader: assembles big-endian words from a stream
// and writes them to instruction RAM, holding the core until done.
module prog_loader #(
  parameter int WORD_W = 16,
  parameter int DEPTH  = 15,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic              cpu_hold
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] GET_LEN = 3'd1;
  localparam logic [2:0] GET_HI  = 3'd2;
  localparam logic [2:0] GET_LO  = 3'd3;
  localparam logic [2:0] GET_CHK = 3'd4;
  localparam logic [2:0] DONE    = 3'd5;
  localparam logic [2:0] ERR     = 3'd6;

  localparam logic [7:0] MAX_LEN = 8'(DEPTH);

  logic [2:0]        state, state_n;
  logic [ADDR_W-1:0] cnt, cnt_inc, len;
  logic [7:0]        hi, chk;
  logic              acc, go, len_ok, busy_n;

  assign in_ready = busy;
  assign acc      = in_valid && busy;
  assign go       = start && !busy;
  assign cnt_inc  = cnt + ADDR_W'(1);
  assign len_ok   = (in_data != 8'd0) && (in_data <= MAX_LEN);
  assign busy_n   = (state_n >= GET_LEN) && (state_n <= GET_CHK);

  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE, ERR:
        if (start) state_n = GET_LEN;
      GET_LEN:
        if (acc) state_n = len_ok ? GET_HI : ERR;
      GET_HI:
        if (acc) state_n = GET_LO;
      GET_LO:
        if (acc) state_n = (cnt_inc == len) ? GET_CHK : GET_HI;
      GET_CHK:
        if (acc) state_n = ((chk ^ in_data) == 8'd0) ? DONE : ERR;
      default:
        state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      done     <= 1'b0;
      error    <= 1'b0;
      cpu_hold <= 1'b0;
      cnt      <= '0;
      len      <= '0;
      hi       <= '0;
      chk      <= '0;
    end else begin
      state <= state_n;
      busy  <= busy_n;
      wr_en <= 1'b0;
      if (go) begin
        done     <= 1'b0;
        error    <= 1'b0;
        cpu_hold <= 1'b1;
        cnt      <= '0;
        chk      <= '0;
      end
      if (acc) begin
        chk <= chk ^ in_data;
        case (state)
          GET_LEN:
            if (len_ok) len <= in_data[ADDR_W-1:0];
          GET_HI:
            hi <= in_data;
          GET_LO: begin
            wr_en   <= 1'b1;
            wr_addr <= cnt;
            wr_data <= {hi, in_data};
            cnt     <= cnt_inc;
          end
          GET_CHK:
            if (state_n == DONE) begin
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end
          default: ;
        endcase
        // hold stays asserted on abort so the core never runs a partial image
        if (state_n == ERR) error <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: scoreboarded writes,
// flow control, bad images and mid-load reset.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, wr_en, busy, done, error, cpu_hold;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;

  int checks = 0;
  int failures = 0;

  logic [19:0] exp_q[$];
  logic [19:0] act_q[$];
  logic [7:0]  img_q[$];
  logic [15:0] wq[$];

  prog_loader dut (
    .clk(clk), .rst(rst), .start(start),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .error(error), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    if (wr_en) act_q.push_back({wr_addr, wr_data});
  end

  // Build LEN, HI/LO pairs and CHK from wq; queue the expected writes
  task automatic build_image();
    logic [7:0] x;
    img_q.delete();
    x = 8'(wq.size());
    img_q.push_back(x);
    foreach (wq[i]) begin
      img_q.push_back(wq[i][15:8]);
      img_q.push_back(wq[i][7:0]);
      x = x ^ wq[i][15:8] ^ wq[i][7:0];
      exp_q.push_back({4'(i), wq[i]});
    end
    img_q.push_back(x);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if ({cpu_hold, busy, done, error} !== 4'b1100) begin
      failures++;
      $display("FAIL start_hold got=%b exp=1100",
               {cpu_hold, busy, done, error});
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    in_valid = 1'b1;
    in_data = b;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      failures++;
      $display("FAIL send_timeout byte=%h in_ready=%b exp=1", b, in_ready);
    end else begin
      @(negedge clk);
    end
  endtask

  task automatic send_image(input int gap_max, input bit noise);
    foreach (img_q[i]) begin
      int g;
      g = $urandom_range(0, gap_max);
      in_valid = 1'b0;
      repeat (g) begin
        start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
      end
      start = 1'b0;
      send_byte(img_q[i]);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({in_ready, wr_en, busy, done, error, cpu_hold, wr_addr, wr_data}
        !== 26'd0) begin
      failures++;
      $display("FAIL reset_outputs got=%h exp=0",
               {in_ready, wr_en, busy, done, error, cpu_hold, wr_addr, wr_data});
    end
    act_q.delete();
    exp_q.delete();
  endtask

  task automatic test_good_len2();
    logic [7:0] b[6] = '{8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    img_q.delete();
    foreach (b[i]) img_q.push_back(b[i]);
    exp_q.push_back({4'd0, 16'h1234});
    exp_q.push_back({4'd1, 16'hABCD});
    pulse_start();
    send_image(0, 1'b0);
    checks++;
    if ({done, error, cpu_hold, busy, in_ready} !== 5'b10000) begin
      failures++;
      $display("FAIL len2_status got=%b exp=10000",
               {done, error, cpu_hold, busy, in_ready});
    end
    repeat (2) @(negedge clk);
    while (exp_q.size() > 0) begin
      logic [19:0] e, a;
      e = exp_q.pop_front();
      a = (act_q.size() > 0) ? act_q.pop_front() : 20'hxxxxx;
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL len2_write got=%h exp=%h", a, e);
      end
    end
    checks++;
    if (act_q.size() != 0) begin
      failures++;
      $display("FAIL len2_extra got=%0d exp=0", act_q.size());
    end
    act_q.delete();
  endtask

  task automatic test_full_depth();
    wq.delete();
    for (int i = 0; i < 15; i++) wq.push_back(16'(i));
    build_image();
    pulse_start();
    send_image(0, 1'b0);
    checks++;
    if ({done, error, cpu_hold} !== 3'b100) begin
      failures++;
      $display("FAIL full_status got=%b exp=100", {done, error, cpu_hold});
    end
    repeat (2) @(negedge clk);
    checks++;
    if (act_q.size() != 15) begin
      failures++;
      $display("FAIL full_count got=%0d exp=15", act_q.size());
    end
    while (exp_q.size() > 0) begin
      logic [19:0] e, a;
      e = exp_q.pop_front();
      a = (act_q.size() > 0) ? act_q.pop_front() : 20'hxxxxx;
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL full_write got=%h exp=%h", a, e);
      end
    end
    act_q.delete();
  endtask

  task automatic test_bad_len();
    logic [7:0] lens[2] = '{8'h00, 8'h10};
    foreach (lens[k]) begin
      pulse_start();
      send_byte(lens[k]);
      in_valid = 1'b0;
      checks++;
      if ({error, done, cpu_hold, in_ready, busy} !== 5'b10100) begin
        failures++;
        $display("FAIL badlen_status len=%h got=%b exp=10100",
                 lens[k], {error, done, cpu_hold, in_ready, busy});
      end
      repeat (2) @(negedge clk);
      checks++;
      if (act_q.size() != 0) begin
        failures++;
        $display("FAIL badlen_writes got=%0d exp=0", act_q.size());
      end
      act_q.delete();
    end
  endtask

  task automatic test_bad_chk();
    logic [7:0] b[4] = '{8'h01, 8'hFF, 8'hFF, 8'h00};
    img_q.delete();
    foreach (b[i]) img_q.push_back(b[i]);
    exp_q.push_back({4'd0, 16'hFFFF});
    pulse_start();
    send_image(0, 1'b0);
    checks++;
    if ({error, done, cpu_hold, busy} !== 4'b1010) begin
      failures++;
      $display("FAIL badchk_status got=%b exp=1010",
               {error, done, cpu_hold, busy});
    end
    repeat (3) @(negedge clk);
    checks++;
    if (cpu_hold !== 1'b1) begin
      failures++;
      $display("FAIL badchk_hold got=%b exp=1", cpu_hold);
    end
    while (exp_q.size() > 0) begin
      logic [19:0] e, a;
      e = exp_q.pop_front();
      a = (act_q.size() > 0) ? act_q.pop_front() : 20'hxxxxx;
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL badchk_write got=%h exp=%h", a, e);
      end
    end
    checks++;
    if (act_q.size() != 0) begin
      failures++;
      $display("FAIL badchk_extra got=%0d exp=0", act_q.size());
    end
    act_q.delete();
  endtask

  task automatic test_flow_control();
    wq.delete();
    for (int i = 0; i < 5; i++) wq.push_back(16'($urandom));
    build_image();
    pulse_start();
    send_image(3, 1'b1);
    checks++;
    if ({done, error, cpu_hold} !== 3'b100) begin
      failures++;
      $display("FAIL flow_status got=%b exp=100", {done, error, cpu_hold});
    end
    repeat (2) @(negedge clk);
    while (exp_q.size() > 0) begin
      logic [19:0] e, a;
      e = exp_q.pop_front();
      a = (act_q.size() > 0) ? act_q.pop_front() : 20'hxxxxx;
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL flow_write got=%h exp=%h", a, e);
      end
    end
    checks++;
    if (act_q.size() != 0) begin
      failures++;
      $display("FAIL flow_extra got=%0d exp=0", act_q.size());
    end
    act_q.delete();
  endtask

  task automatic test_reset_mid_load();
    logic [7:0] b[4] = '{8'h02, 8'h12, 8'h34, 8'hAB};
    pulse_start();
    foreach (b[i]) send_byte(b[i]);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({in_ready, wr_en, busy, done, error, cpu_hold, wr_addr, wr_data}
        !== 26'd0) begin
      failures++;
      $display("FAIL rstmid_outputs got=%h exp=0",
               {in_ready, wr_en, busy, done, error, cpu_hold, wr_addr, wr_data});
    end
    repeat (3) @(negedge clk);
    checks++;
    if (act_q.size() != 1 || act_q[0] !== {4'd0, 16'h1234}) begin
      failures++;
      $display("FAIL rstmid_writes got=%0d first=%h exp=1 first=01234",
               act_q.size(), (act_q.size() > 0) ? act_q[0] : 20'h0);
    end
    act_q.delete();
    wq.delete();
    wq.push_back(16'hBEEF);
    wq.push_back(16'h0042);
    build_image();
    pulse_start();
    send_image(1, 1'b0);
    checks++;
    if ({done, error, cpu_hold} !== 3'b100) begin
      failures++;
      $display("FAIL rstmid_reload got=%b exp=100", {done, error, cpu_hold});
    end
    repeat (2) @(negedge clk);
    while (exp_q.size() > 0) begin
      logic [19:0] e, a;
      e = exp_q.pop_front();
      a = (act_q.size() > 0) ? act_q.pop_front() : 20'hxxxxx;
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL rstmid_write got=%h exp=%h", a, e);
      end
    end
    act_q.delete();
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_good_len2();
    test_full_depth();
    test_bad_len();
    test_bad_chk();
    test_flow_control();
    test_reset_mid_load();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
